// File: rtl/mult_patches_pkg.sv
// Shared types and constants for the fixed-point drum membrane solver.
package mult_patches_pkg;

  typedef logic signed [17:0] fix_t;

  localparam int FRAC_BITS = 17;

  typedef enum logic [1:0] {
    S0_SETTLE  = 2'd0,
    S1_SAMPLE  = 2'd1,
    S2_COMPUTE = 2'd2,
    S3_COMMIT  = 2'd3
  } phase_e;

endpackage

// File: rtl/mult_patches_if.sv
// Grid-wide bus between the solver and its feedback/control environment.
interface mult_patches_if #(
  parameter int SIZE = 4
);
  import mult_patches_pkg::*;

  fix_t u_hit_mid [SIZE][SIZE];
  fix_t u_1_right [SIZE][SIZE];
  fix_t u_1_left  [SIZE][SIZE];
  fix_t u_1_up    [SIZE][SIZE];
  fix_t u_1_down  [SIZE][SIZE];
  fix_t rho;
  fix_t u_2_mid   [SIZE][SIZE];
  logic iterFlag;

  modport master (
    output u_hit_mid, u_1_right, u_1_left, u_1_up, u_1_down, rho,
    input  u_2_mid, iterFlag
  );

  modport slave (
    input  u_hit_mid, u_1_right, u_1_left, u_1_up, u_1_down, rho,
    output u_2_mid, iterFlag
  );

endinterface

// File: rtl/mult_patches_drum_node.sv
// One membrane node: holds the current/previous displacement and the damped update datapath.
module drum_node
  import mult_patches_pkg::*;
#(
  parameter int ETA_SHIFT = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_en_i,
  input  logic compute_en_i,
  input  logic commit_en_i,
  input  fix_t hit_i,
  input  fix_t r_i,
  input  fix_t l_i,
  input  fix_t u_i,
  input  fix_t d_i,
  input  fix_t rho_i,
  output fix_t u_o
);

  function automatic fix_t sat_lap(input logic signed [20:0] v);
    if (v > 21'sd131071)       return 18'sh1FFFF;
    else if (v < -21'sd131072) return 18'sh20000;
    else                       return v[17:0];
  endfunction

  logic signed [20:0] lap_d, lap_p1_q;
  fix_t rho_p1_q, lap_sat_p1, p_d, p_p2_q;
  fix_t t_d, u_cur_d, u_cur_q, u_prev_q;

  always_comb begin
    lap_d = 21'(r_i) + 21'(l_i) + 21'(u_i) + 21'(d_i) - (21'(u_cur_q) <<< 2);
  end

  // Stage p1: neighbour sum and coefficient captured during SAMPLE
  always_ff @(posedge clock) begin
    if (sample_en_i) begin
      lap_p1_q <= lap_d;
      rho_p1_q <= rho_i;
    end
  end

  assign lap_sat_p1 = sat_lap(lap_p1_q);

  signed_mult_1_17 u_mult (
    .out (p_d),
    .a   (rho_p1_q),
    .b   (lap_sat_p1)
  );

  // Stage p2: coupling term captured during COMPUTE
  always_ff @(posedge clock) begin
    if (compute_en_i) p_p2_q <= p_d;
  end

  always_comb begin
    t_d     = p_p2_q + (u_cur_q <<< 1) - u_prev_q;
    u_cur_d = t_d - (t_d >>> ETA_SHIFT);
  end

  // Commit: leapfrog the displacement history; reset starts at rest on the hit shape
  always_ff @(posedge clock) begin
    if (reset) begin
      u_cur_q  <= hit_i;
      u_prev_q <= hit_i;
    end else if (commit_en_i) begin
      u_cur_q  <= u_cur_d;
      u_prev_q <= u_cur_q;
    end
  end

  assign u_o = u_cur_q;

endmodule

// File: rtl/signed_mult_1_17.sv
// Combinational 1.17 x 1.17 -> 1.17 signed multiplier (sign bit plus 17 fraction bits).
module signed_mult_1_17
  import mult_patches_pkg::*;
(
  output fix_t out,
  input  fix_t a,
  input  fix_t b
);

  logic signed [35:0] prod;
  logic               unused_prod;

  assign prod        = a * b;
  // The two integer bits collapse to one: operands in 1.17 never need both.
  assign out         = {prod[35], prod[2*FRAC_BITS-1:FRAC_BITS]};
  assign unused_prod = ^{prod[34], prod[FRAC_BITS-1:0]};

endmodule

// File: rtl/mult_patches.sv
// Drum membrane solver top: four-phase iteration sequencer and fixed-boundary neighbour wiring.
module mult_patches
  import mult_patches_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int ETA_SHIFT = 10
) (
  input  logic           clock,
  input  logic           reset,
  mult_patches_if.slave  bus
);

  phase_e phase_q, phase_d;
  logic   iter_flag_q;
  logic   sample_en, compute_en, commit_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= S0_SETTLE;
      iter_flag_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      iter_flag_q <= commit_en;
    end
  end

  always_comb begin
    phase_d = S0_SETTLE;
    unique case (phase_q)
      S0_SETTLE:  phase_d = S1_SAMPLE;
      S1_SAMPLE:  phase_d = S2_COMPUTE;
      S2_COMPUTE: phase_d = S3_COMMIT;
      S3_COMMIT:  phase_d = S0_SETTLE;
      default:    phase_d = S0_SETTLE;
    endcase
  end

  always_comb begin
    sample_en  = (phase_q == S1_SAMPLE);
    compute_en = (phase_q == S2_COMPUTE);
    commit_en  = (phase_q == S3_COMMIT);
  end

  assign bus.iterFlag = iter_flag_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      fix_t r_w, l_w, u_w, d_w, node_w;

      // Neighbours beyond the grid edge are the clamped (zero) membrane rim
      if (j < SIZE-1) begin : g_r  assign r_w = bus.u_1_right[i][j+1]; end
      else            begin : g_rz assign r_w = '0;                     end
      if (j > 0)      begin : g_l  assign l_w = bus.u_1_left[i][j-1];  end
      else            begin : g_lz assign l_w = '0;                     end
      if (i > 0)      begin : g_u  assign u_w = bus.u_1_up[i-1][j];    end
      else            begin : g_uz assign u_w = '0;                     end
      if (i < SIZE-1) begin : g_d  assign d_w = bus.u_1_down[i+1][j];  end
      else            begin : g_dz assign d_w = '0;                     end

      drum_node #(.ETA_SHIFT(ETA_SHIFT)) u_node (
        .clock        (clock),
        .reset        (reset),
        .sample_en_i  (sample_en),
        .compute_en_i (compute_en),
        .commit_en_i  (commit_en),
        .hit_i        (bus.u_hit_mid[i][j]),
        .r_i          (r_w),
        .l_i          (l_w),
        .u_i          (u_w),
        .d_i          (d_w),
        .rho_i        (bus.rho),
        .u_o          (node_w)
      );

      assign bus.u_2_mid[i][j] = node_w;
    end
  end

  logic [SIZE-1:0] unused_edge;
  for (genvar k = 0; k < SIZE; k++) begin : g_edge
    assign unused_edge[k] = ^{bus.u_1_right[k][0], bus.u_1_left[k][SIZE-1],
                              bus.u_1_up[SIZE-1][k], bus.u_1_down[0][k]};
  end

endmodule

// File: tb/tb_mult_patches.sv
// Scoreboard bench for mult_patches: stimulus queues expected grids, a monitor checks each iterFlag.
module tb_mult_patches;
  import mult_patches_pkg::*;

  localparam int N = 4;
  typedef logic [N*N*18-1:0] grid_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mult_patches_if #(.SIZE(N)) bus ();
  mult_patches #(.SIZE(N), .ETA_SHIFT(10)) dut (.clock(clock), .reset(reset), .bus(bus));

  fix_t hit_a [N][N];
  fix_t rho_v;
  assign bus.u_hit_mid = hit_a;
  assign bus.rho       = rho_v;
  assign bus.u_1_right = bus.u_2_mid;
  assign bus.u_1_left  = bus.u_2_mid;
  assign bus.u_1_up    = bus.u_2_mid;
  assign bus.u_1_down  = bus.u_2_mid;

  fix_t ma, mb, mo;
  signed_mult_1_17 u_mchk (.out(mo), .a(ma), .b(mb));

  int    total = 0;
  int    bad   = 0;
  grid_t exp_q [$];
  bit    sym_chk = 0, period_chk = 0, have_last = 0;
  int    cyc = 0, last_cyc = 0;
  grid_t mon_got, mon_exp;

  fix_t m_cur [N][N];
  fix_t m_prev [N][N];

  function automatic void put(inout grid_t g, input int i, input int j, input fix_t v);
    g[(i*N+j)*18 +: 18] = v;
  endfunction

  function automatic grid_t pack_dut();
    grid_t g = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) put(g, i, j, bus.u_2_mid[i][j]);
    return g;
  endfunction

  function automatic grid_t pack_hit();
    grid_t g = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) put(g, i, j, hit_a[i][j]);
    return g;
  endfunction

  function automatic grid_t pack_model();
    grid_t g = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) put(g, i, j, m_cur[i][j]);
    return g;
  endfunction

  // First iteration of a 0x04000 strike at [2][2] with rho=0x01999, worked by hand
  function automatic grid_t hand_iter1();
    grid_t g = '0;
    put(g, 2, 2, 18'sh03327);
    put(g, 2, 1, 18'sh00333);
    put(g, 2, 3, 18'sh00333);
    put(g, 1, 2, 18'sh00333);
    put(g, 3, 2, 18'sh00333);
    return g;
  endfunction

  function automatic bit sym_ok();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (bus.u_2_mid[i][j] !== bus.u_2_mid[N-1-i][N-1-j] ||
            bus.u_2_mid[i][j] !== bus.u_2_mid[j][i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nb(input int i, input int j);
    if (i < 0 || i >= N || j < 0 || j >= N) return 0;
    return int'(m_cur[i][j]);
  endfunction

  task automatic model_init();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m_cur[i][j]  = hit_a[i][j];
        m_prev[i][j] = hit_a[i][j];
      end
  endtask

  task automatic model_step(input fix_t r);
    fix_t   nxt [N][N];
    int     lap, t_i;
    longint prod;
    fix_t   p, t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        lap  = nb(i, j+1) + nb(i, j-1) + nb(i-1, j) + nb(i+1, j) - 4 * int'(m_cur[i][j]);
        prod = longint'(r) * longint'(lap);
        p    = fix_t'(prod >>> 17);
        t    = fix_t'(int'(p) + 2 * int'(m_cur[i][j]) - int'(m_prev[i][j]));
        t_i  = int'(t);
        nxt[i][j] = fix_t'(t_i - (t_i >>> 10));
      end
    m_prev = m_cur;
    m_cur  = nxt;
  endtask

  // Monitor: every iterFlag pops one expected grid
  always @(negedge clock) begin
    if (bus.iterFlag === 1'b1) begin
      mon_got = pack_dut();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_flag: got iterFlag=1 with grid=%h, required no pending iteration", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL grid: got=%h required=%h", mon_got, mon_exp);
        end
      end
      if (sym_chk) begin
        total++;
        if (!sym_ok()) begin
          bad++;
          $display("FAIL symmetry: got asymmetric grid=%h required symmetric", mon_got);
        end
      end
      if (period_chk && have_last) begin
        total++;
        if (cyc - last_cyc != 4) begin
          bad++;
          $display("FAIL flag_period: got=%0d required=4", cyc - last_cyc);
        end
      end
      last_cyc  = cyc;
      have_last = period_chk;
    end
    cyc++;
  end

  task automatic chk_mult(input fix_t a, input fix_t b, input fix_t e);
    ma = a; mb = b;
    #1;
    total++;
    if (mo !== e) begin
      bad++;
      $display("FAIL mult %h*%h: got=%h required=%h", a, b, mo, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if (pack_dut() !== pack_hit() || bus.iterFlag !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got grid=%h flag=%b required grid=%h flag=0",
               pack_dut(), bus.iterFlag, pack_hit());
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic wait_until(input int left, input int budget, input bit hold_reset);
    int n = 0;
    while (exp_q.size() > left && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    if (exp_q.size() > left) begin
      total++; bad++;
      $display("FAIL timeout: pending=%0d required=%0d", exp_q.size(), left);
      exp_q.delete();
    end
    if (hold_reset) reset = 1'b1;
  endtask

  task automatic set_hit_zero();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) hit_a[i][j] = '0;
  endtask

  initial begin
    int first;
    set_hit_zero();
    rho_v = 18'sh01999;

    chk_mult(18'sh10000, 18'sh10000, 18'sh08000);
    chk_mult(18'sh30000, 18'sh10000, 18'sh38000);
    chk_mult(18'sh00000, 18'sh1FFFF, 18'sh00000);
    chk_mult(18'sh00000, 18'sh2A5A5, 18'sh00000);

    // All-zero membrane stays at rest, flags every 4 clocks
    period_chk = 1;
    for (int k = 0; k < 20; k++) exp_q.push_back('0);
    do_reset();
    wait_until(0, 100, 1);
    period_chk = 0;

    // Single strike with full feedback
    hit_a[2][2] = 18'sh04000;
    exp_q.push_back(hand_iter1());
    model_init();
    model_step(18'sh01999);
    for (int k = 0; k < 5; k++) begin
      model_step(18'sh01999);
      exp_q.push_back(pack_model());
    end
    do_reset();
    wait_until(0, 40, 1);

    // Centre-symmetric strike stays symmetric
    set_hit_zero();
    hit_a[1][1] = 18'sh06000; hit_a[1][2] = 18'sh06000;
    hit_a[2][1] = 18'sh06000; hit_a[2][2] = 18'sh06000;
    model_init();
    for (int k = 0; k < 8; k++) begin
      model_step(18'sh01999);
      exp_q.push_back(pack_model());
    end
    sym_chk = 1;
    do_reset();
    wait_until(0, 50, 1);
    sym_chk = 0;

    // Reset during COMPUTE discards the partial iteration
    set_hit_zero();
    hit_a[2][2] = 18'sh04000;
    exp_q.push_back(hand_iter1());
    do_reset();
    wait_until(0, 20, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if (pack_dut() !== pack_hit()) begin
      bad++;
      $display("FAIL midreset_grid: got=%h required=%h", pack_dut(), pack_hit());
    end
    total++;
    if (bus.iterFlag !== 1'b0) begin
      bad++;
      $display("FAIL midreset_flag: got=%b required=0", bus.iterFlag);
    end
    reset = 1'b0;
    exp_q.push_back(hand_iter1());
    first = 0;
    for (int k = 1; k <= 6 && first == 0; k++) begin
      @(posedge clock); #1;
      if (bus.iterFlag === 1'b1) first = k;
    end
    total++;
    if (first != 4) begin
      bad++;
      $display("FAIL first_flag_edge: got=%0d required=4", first);
    end
    wait_until(0, 10, 1);

    // Coupling change at an iteration boundary
    rho_v = 18'sh01999;
    model_init();
    model_step(18'sh01999);
    exp_q.push_back(pack_model());
    for (int k = 0; k < 2; k++) begin
      model_step(18'sh0F5C2);
      exp_q.push_back(pack_model());
    end
    do_reset();
    wait_until(2, 20, 0);
    rho_v = 18'sh0F5C2;
    wait_until(0, 20, 1);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
